// File: rtl/operand_collector_if.sv
// Operand, adder and result channels between the collector and its neighbours.
// The collector takes the slave modport; the upstream, adder and router side takes master.
interface operand_collector_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_a_data;
    logic             in_a_valid;
    logic             in_a_ready;
    logic [WIDTH-1:0] in_b_data;
    logic             in_b_valid;
    logic             in_b_ready;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_on_off;
    logic [WIDTH-1:0] add_c;
    logic             add_carry;
    logic             add_ack;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output in_a_data, in_a_valid, in_b_data, in_b_valid,
        output add_c, add_carry, add_ack, res_ready,
        input  in_a_ready, in_b_ready, add_a, add_b, add_on_off,
        input  res_data, res_carry, res_valid
    );

    modport slave (
        input  in_a_data, in_a_valid, in_b_data, in_b_valid,
        input  add_c, add_carry, add_ack, res_ready,
        output in_a_ready, in_b_ready, add_a, add_b, add_on_off,
        output res_data, res_carry, res_valid
    );
endinterface

// File: rtl/operand_collector.sv
// Pairs operands from two 2-deep FIFOs, issues them to the adder and holds the result; 2 cycles issue-to-result.
// Input ready is count-based (no path from pop); a held result blocks further issues; err is a sticky ack timeout.
module operand_collector #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    operand_collector_if.slave    bus,
    output logic                  err
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    tmo_cnt;
    logic [WIDTH-1:0] add_a_q, add_b_q, res_data_q;
    logic             on_off_q, res_carry_q, res_valid_q, err_q;

    logic [WIDTH-1:0] a_mem [2];
    logic [WIDTH-1:0] b_mem [2];
    logic             a_wp, a_rp, b_wp, b_rp;
    logic [1:0]       a_cnt, b_cnt;
    logic             a_push, b_push, issue;

    assign bus.in_a_ready = (a_cnt != 2'd2);
    assign bus.in_b_ready = (b_cnt != 2'd2);
    assign a_push = bus.in_a_valid & bus.in_a_ready;
    assign b_push = bus.in_b_valid & bus.in_b_ready;
    assign issue  = (state == IDLE) & enable & (a_cnt != 2'd0) & (b_cnt != 2'd0);

    // Storage needs no reset: occupancy is tracked by the pointers/counts below.
    always_ff @(posedge clk) begin
        if (a_push) a_mem[a_wp] <= bus.in_a_data;
        if (b_push) b_mem[b_wp] <= bus.in_b_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_wp  <= 1'b0;
            a_rp  <= 1'b0;
            a_cnt <= 2'd0;
            b_wp  <= 1'b0;
            b_rp  <= 1'b0;
            b_cnt <= 2'd0;
        end else begin
            if (a_push) a_wp <= ~a_wp;
            if (b_push) b_wp <= ~b_wp;
            if (issue) begin
                a_rp <= ~a_rp;
                b_rp <= ~b_rp;
            end
            a_cnt <= a_cnt + {1'b0, a_push} - {1'b0, issue};
            b_cnt <= b_cnt + {1'b0, b_push} - {1'b0, issue};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            on_off_q    <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        add_a_q  <= a_mem[a_rp];
                        add_b_q  <= b_mem[b_rp];
                        on_off_q <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (bus.add_ack) begin
                        res_data_q  <= bus.add_c;
                        res_carry_q <= bus.add_carry;
                        res_valid_q <= 1'b1;
                        on_off_q    <= 1'b0;
                        state       <= DONE;
                    end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        err_q    <= 1'b1;
                        on_off_q <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.add_on_off = on_off_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_carry  = res_carry_q;
    assign bus.res_valid  = res_valid_q;
    assign err            = err_q;
endmodule
